freq_meter: RTL
===============

Name: freq_meter

Overview:
- Gated frequency counter: the measuring counterpart to the system clock divider.
- The divider derives a slow timebase from clk. This block measures an unknown external signal against clk.
- It counts rising edges of the asynchronous input sig_in during a fixed gate window of GATE_CYCLES clk cycles, then latches the count as the result.
- With the default 1 s gate at 50 MHz, the result reads directly in Hz. The result feeds display/BCD logic downstream.

Parameters:
- GATE_CYCLES, 50000000: gate window length in clk cycles (default gives a 1 s gate at 50 MHz).
- CNT_W, 27: width of the edge counter and of freq.

Ports:
- clk  input  1  system clock (50 MHz nominal).
- clr_n  input  1  asynchronous active-low reset.
- sig_in  input  1  signal under measurement; asynchronous to clk.
- start  input  1  single-shot measurement request; sampled in IDLE only.
- cont  input  1  continuous mode; level-sensitive.
- freq  output  CNT_W  rising-edge count from the last completed window (saturating).
- valid  output  1  one-cycle pulse when freq/ovf update.
- busy  output  1  high while a window is open.
- ovf  output  1  edge count saturated in the last completed window.

Behaviour:
- Reset:
  - clr_n is asynchronous, active-low; clock is clk.
  - On reset: freq=0, valid=0, busy=0, ovf=0, FSM=IDLE, all counters 0, sync chain 0, primed=0.
- Input synchronizer and edge detect:
  - Chain s1 -> s2 -> s3, all reset to 0.
  - edge = s2 & ~s3 & primed.
  - primed sets 3 cycles after reset release. This suppresses a false edge when sig_in is high at reset.
  - Latency from a sig_in rise to edge is 2-3 clk.
  - Resolvable input frequency is at most clk/2. Pulses shorter than one clk period may be missed; this is accepted.
- FSM state IDLE:
  - busy=0.
  - If start=1 or cont=1: next state MEAS, gate_cnt=0, edge_cnt=0.
- FSM state MEAS:
  - busy=1.
  - gate_cnt increments every cycle from 0 to GATE_CYCLES-1. The window is exactly GATE_CYCLES cycles.
  - On each cycle with edge=1, edge_cnt increments, saturating at 2^CNT_W-1. If an increment is attempted at max, a window-local sticky ovf_w flag is set.
  - start is ignored in MEAS.
  - On the cycle where gate_cnt==GATE_CYCLES-1, at that clock edge:
    - freq <= edge_cnt + edge, saturated (an edge in the final cycle counts);
    - ovf <= ovf_w, or overflow caused by that final add;
    - valid <= 1 for exactly the next cycle.
  - Next state after the final cycle:
    - cont=1: stay in MEAS, counters cleared. The next window starts immediately with no gap cycle.
    - cont=0: go to IDLE.
- Counting rules:
  - Edges arriving while in IDLE are not counted.
  - freq and ovf hold their values between updates.
- Reset mid-window:
  - Aborts the window.
  - No valid pulse is issued.
  - All outputs return to their reset values.
- Dropping cont mid-window: the current window completes normally, then the FSM returns to IDLE.

Test Plan (bench uses GATE_CYCLES=100, CNT_W=8 unless stated):
- Reset: assert clr_n low with sig_in toggling -> freq=0, valid=0, busy=0, ovf=0; all stay 0 with start=0, cont=0 after release.
- Single shot: sig_in period 10 clk, one-cycle start pulse -> busy high for exactly 100 cycles; valid pulses once; freq=10; ovf=0; busy=0 afterwards.
- Continuous: cont=1, sig_in period 4 clk -> valid every 100 cycles with no gap; freq=25 each time. Drop cont mid-window -> that window completes, then IDLE.
- Overflow: CNT_W=4, period 4 -> freq=15, ovf=1. Next window with period 20 -> freq=5, ovf=0.
- Reset mid-window: clr_n low at gate cycle 50 -> no valid; freq=0, busy=0. A fresh start then yields the correct count.
- Edge cases:
  - sig_in held high through reset and the window -> freq=0.
  - start pulsed while busy -> ignored, single result.
  - A rising edge timed to land on the final gate cycle -> included in freq.

Source files
------------

// File: rtl/freq_meter.sv
// Gated frequency counter: counts rising edges of the asynchronous sig_in over
// a window of GATE_CYCLES clk cycles and latches a saturating result.
module freq_meter #(
    parameter int GATE_CYCLES = 50000000,
    parameter int CNT_W       = 27
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             sig_in,
    input  logic             start,
    input  logic             cont,
    output logic [CNT_W-1:0] freq,
    output logic             valid,
    output logic             busy,
    output logic             ovf
);

    localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;

    typedef enum logic {
        IDLE,
        MEAS
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             s1;
    logic             s2;
    logic             s3;
    logic             primed;
    logic [1:0]       prime_cnt;
    logic             sig_edge;
    logic [GW-1:0]    gate_cnt;
    logic [CNT_W-1:0] edge_cnt;
    logic             ovf_w;
    logic             gate_last;
    logic             at_max;
    logic [CNT_W-1:0] final_sum;
    logic             final_ovf;

    // primed holds off edge detection until the chain has filled with real
    // samples, so a level already high at reset release is not seen as a rise.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            s1        <= 1'b0;
            s2        <= 1'b0;
            s3        <= 1'b0;
            prime_cnt <= '0;
            primed    <= 1'b0;
        end else begin
            s1 <= sig_in;
            s2 <= s1;
            s3 <= s2;
            if (!primed) begin
                prime_cnt <= prime_cnt + 2'd1;
                primed    <= (prime_cnt == 2'd2);
            end
        end
    end

    assign sig_edge  = s2 & ~s3 & primed;
    assign gate_last = (gate_cnt == GW'(GATE_CYCLES - 1));
    assign at_max    = (edge_cnt == '1);
    assign final_ovf = sig_edge & at_max;
    assign final_sum = (sig_edge && !at_max) ? edge_cnt + CNT_W'(1) : edge_cnt;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                if (start || cont) begin
                    state_nxt = MEAS;
                end
            end
            MEAS: begin
                busy = 1'b1;
                if (gate_last && !cont) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Counters are held cleared in IDLE so every window starts from zero.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            gate_cnt <= '0;
            edge_cnt <= '0;
            ovf_w    <= 1'b0;
            freq     <= '0;
            ovf      <= 1'b0;
            valid    <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (state == IDLE) begin
                gate_cnt <= '0;
                edge_cnt <= '0;
                ovf_w    <= 1'b0;
            end else if (gate_last) begin
                freq     <= final_sum;
                ovf      <= ovf_w | final_ovf;
                valid    <= 1'b1;
                gate_cnt <= '0;
                edge_cnt <= '0;
                ovf_w    <= 1'b0;
            end else begin
                gate_cnt <= gate_cnt + GW'(1);
                if (sig_edge) begin
                    if (at_max) begin
                        ovf_w <= 1'b1;
                    end else begin
                        edge_cnt <= edge_cnt + CNT_W'(1);
                    end
                end
            end
        end
    end

endmodule
